// File: rtl/lsu_pkg.sv
// Shared types, funct3/error encodings and size helpers for the pipe_lsu
// load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // funct3[1:0] encodes log2 of the access size in bytes
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] align_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic [2:0] funct3,
                                          input logic       we,
                                          input logic       wide);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_D:             return wide;
            F3_BU, F3_HU:     return !we;
            F3_WU:            return !we && wide;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data replication and byte enables,
// load lane selection with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                    funct3,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH-1:0]         rdata,
    output logic [DATA_WIDTH-1:0]         wdata_rep,
    output logic [DATA_WIDTH/8-1:0]       be,
    output logic [DATA_WIDTH-1:0]         rdata_ext
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            case (funct3[1:0])
                2'b00:   wdata_rep[i*8 +: 8] = wdata[7:0];
                2'b01:   wdata_rep[i*8 +: 8] = wdata[(i % 2)*8 +: 8];
                2'b10:   wdata_rep[i*8 +: 8] = wdata[(i % 4)*8 +: 8];
                default: wdata_rep[i*8 +: 8] = wdata[i*8 +: 8];
            endcase
        end
    end

    assign be = NB'(NB'(size_mask(funct3)) << offset);

    // Move the addressed lane down to bit 0 before extending
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        case (funct3)
            F3_B:    rdata_ext = DATA_WIDTH'($signed(shifted[7:0]));
            F3_H:    rdata_ext = DATA_WIDTH'($signed(shifted[15:0]));
            F3_W:    rdata_ext = DATA_WIDTH'($signed(shifted[31:0]));
            F3_BU:   rdata_ext = DATA_WIDTH'(shifted[7:0]);
            F3_HU:   rdata_ext = DATA_WIDTH'(shifted[15:0]);
            F3_WU:   rdata_ext = DATA_WIDTH'(shifted[31:0]);
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/pipe_lsu.sv
// MEM-stage load/store unit: turns a pipeline memory request into a
// req/ack bus transaction, stalling the pipeline until it completes.
module pipe_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_MAX   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    stall_o,
    output logic                    rsp_valid,
    output logic                    rsp_load,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              err_code,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam logic       WIDE      = (DATA_WIDTH == 64);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NB - 1);

    lsu_state_t state, state_next;

    logic [7:0]            wait_cnt;
    logic [2:0]            cur_funct3;
    logic [OFF-1:0]        cur_offset;
    logic                  legal, misaligned;
    logic [2:0]            align_funct3;
    logic [OFF-1:0]        align_offset;
    logic [DATA_WIDTH-1:0] wdata_rep, rdata_ext;
    logic [NB-1:0]         store_be;

    assign legal      = funct3_legal(req_funct3, req_we, WIDE);
    assign misaligned = |(3'(req_addr[OFF-1:0]) & align_mask(req_funct3));

    // Store steering uses the incoming request; load extension uses the latched one
    assign align_funct3 = (state == ST_IDLE) ? req_funct3 : cur_funct3;
    assign align_offset = (state == ST_IDLE) ? req_addr[OFF-1:0] : cur_offset;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3    (align_funct3),
        .offset    (align_offset),
        .wdata     (req_wdata),
        .rdata     (bus_rdata),
        .wdata_rep (wdata_rep),
        .be        (store_be),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_o = req_valid;
                if (req_valid) state_next = (legal && !misaligned) ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                stall_o = 1'b1;
                if (bus_ack || wait_cnt == WAIT_LAST) state_next = ST_RESP;
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt   <= '0;
            cur_funct3 <= '0;
            cur_offset <= '0;
            rsp_valid  <= 1'b0;
            rsp_load   <= 1'b0;
            rsp_rdata  <= '0;
            err_code   <= ERR_NONE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (req_valid) begin
                        cur_funct3 <= req_funct3;
                        cur_offset <= req_addr[OFF-1:0];
                        rsp_load   <= !req_we;
                        if (legal && !misaligned) begin
                            bus_req   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= req_addr & ~OFF_MASK;
                            bus_wdata <= req_we ? wdata_rep : '0;
                            bus_be    <= req_we ? store_be : '1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            err_code  <= legal ? ERR_MISALIGN : ERR_ILLEGAL;
                        end
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // An ack on the final wait cycle takes priority over timeout
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= bus_we ? '0 : rdata_ext;
                        err_code  <= ERR_NONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        err_code  <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_lsu.sv
// Self-checking bench for pipe_lsu: 32-bit table-driven vectors with a
// response scoreboard, plus reset and 64-bit lane sequences.
module tb_pipe_lsu;

    localparam int TB_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall_o, rsp_valid, rsp_load;
    logic [31:0] rsp_rdata;
    logic [1:0]  err_code;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    logic        req_valid_w, req_we_w;
    logic [2:0]  req_funct3_w;
    logic [31:0] req_addr_w;
    logic [63:0] req_wdata_w;
    logic        stall_o_w, rsp_valid_w, rsp_load_w;
    logic [63:0] rsp_rdata_w;
    logic [1:0]  err_code_w;
    logic        bus_req_w, bus_we_w, bus_ack_w;
    logic [31:0] bus_addr_w;
    logic [63:0] bus_wdata_w, bus_rdata_w;
    logic [7:0]  bus_be_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          ack_at;
        logic        access;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    typedef struct {
        logic        load;
        logic [31:0] rdata;
        logic [1:0]  err;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[20];

    always #5 clk = ~clk;

    pipe_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_MAX(TB_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall_o(stall_o), .rsp_valid(rsp_valid), .rsp_load(rsp_load),
        .rsp_rdata(rsp_rdata), .err_code(err_code),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    pipe_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .WAIT_MAX(15)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_w), .req_we(req_we_w), .req_funct3(req_funct3_w),
        .req_addr(req_addr_w), .req_wdata(req_wdata_w),
        .stall_o(stall_o_w), .rsp_valid(rsp_valid_w), .rsp_load(rsp_load_w),
        .rsp_rdata(rsp_rdata_w), .err_code(err_code_w),
        .bus_req(bus_req_w), .bus_we(bus_we_w), .bus_addr(bus_addr_w),
        .bus_wdata(bus_wdata_w), .bus_be(bus_be_w),
        .bus_ack(bus_ack_w), .bus_rdata(bus_rdata_w)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, wdata, rdata,
                                input int ack_at, input logic access,
                                input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, exp_rdata,
                                input logic [1:0] exp_err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.ack_at = ack_at; v.access = access; v.exp_addr = exp_addr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err;
        return v;
    endfunction

    // Every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        sb_t e;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected no response");
            end else begin
                e = sb_q.pop_front();
                checkOutput("rsp_load", 64'(rsp_load), 64'(e.load));
                checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                checkOutput("err_code", 64'(err_code), 64'(e.err));
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input int idx);
        sb_t e;
        int  n_req;
        int  exp_n;
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; bus_rdata = v.rdata;
        e.load = !v.we; e.rdata = v.exp_rdata; e.err = v.exp_err;
        sb_q.push_back(e);
        #1 checkOutput($sformatf("v%0d stall_idle", idx), 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        n_req = 0;
        while (bus_req && n_req < 64) begin
            if (n_req == 0) begin
                checkOutput($sformatf("v%0d bus_addr", idx), 64'(bus_addr), 64'(v.exp_addr));
                checkOutput($sformatf("v%0d bus_be", idx), 64'(bus_be), 64'(v.exp_be));
                checkOutput($sformatf("v%0d bus_we", idx), 64'(bus_we), 64'(v.we));
                if (v.we)
                    checkOutput($sformatf("v%0d bus_wdata", idx), 64'(bus_wdata), 64'(v.exp_wdata));
            end
            checkOutput($sformatf("v%0d stall_access", idx), 64'(stall_o), 64'd1);
            bus_ack = (n_req == v.ack_at);
            n_req++;
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        exp_n = !v.access ? 0 : (v.ack_at >= 0 ? v.ack_at + 1 : TB_WAIT);
        checkOutput($sformatf("v%0d req_cycles", idx), 64'(n_req), 64'(exp_n));
        checkOutput($sformatf("v%0d rsp_valid", idx), 64'(rsp_valid), 64'd1);
        checkOutput($sformatf("v%0d stall_resp", idx), 64'(stall_o), 64'd0);
        // Request is still presented during RESP and must not start a new access
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d resp_ignored", idx), 64'(bus_req), 64'd0);
        req_valid = 1'b0;
    endtask

    task automatic run64(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wdata, rdata,
                         input logic [31:0] exp_addr, input logic [7:0] exp_be,
                         input logic [63:0] exp_wdata, exp_rdata);
        req_valid_w = 1'b1; req_we_w = we; req_funct3_w = f3;
        req_addr_w = addr; req_wdata_w = wdata; bus_rdata_w = rdata;
        @(posedge clk); #1;
        checkOutput({name, " bus_req"}, 64'(bus_req_w), 64'd1);
        checkOutput({name, " bus_addr"}, 64'(bus_addr_w), 64'(exp_addr));
        checkOutput({name, " bus_be"}, 64'(bus_be_w), 64'(exp_be));
        if (we) checkOutput({name, " bus_wdata"}, bus_wdata_w, exp_wdata);
        bus_ack_w = 1'b1;
        @(posedge clk); #1;
        bus_ack_w = 1'b0;
        req_valid_w = 1'b0;
        checkOutput({name, " rsp_valid"}, 64'(rsp_valid_w), 64'd1);
        checkOutput({name, " rsp_rdata"}, rsp_rdata_w, exp_rdata);
        checkOutput({name, " err_code"}, 64'(err_code_w), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 32'h100, 4'hF, 0, 32'hDEADBEEF, 2'b00);
        vecs[1]  = mk(0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 1, 32'h100, 4'hF, 0, 32'hFFFFFF80, 2'b00);
        vecs[2]  = mk(0, 3'b100, 32'h103, 0, 32'h80FF0000, 1, 1, 32'h100, 4'hF, 0, 32'h00000080, 2'b00);
        vecs[3]  = mk(1, 3'b001, 32'h202, 32'h1234ABCD, 0, 1, 1, 32'h200, 4'hC, 32'hABCDABCD, 0, 2'b00);
        vecs[4]  = mk(0, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        vecs[5]  = mk(0, 3'b111, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
        vecs[6]  = mk(0, 3'b010, 32'h300, 0, 32'h55555555, -1, 1, 32'h300, 4'hF, 0, 0, 2'b10);
        vecs[7]  = mk(0, 3'b010, 32'h300, 0, 32'h12345678, 3, 1, 32'h300, 4'hF, 0, 32'h12345678, 2'b00);
        vecs[8]  = mk(0, 3'b001, 32'h102, 0, 32'h80011234, 2, 1, 32'h100, 4'hF, 0, 32'hFFFF8001, 2'b00);
        vecs[9]  = mk(0, 3'b101, 32'h100, 0, 32'h0000F00F, 0, 1, 32'h100, 4'hF, 0, 32'h0000F00F, 2'b00);
        vecs[10] = mk(1, 3'b000, 32'h105, 32'h000000A5, 32'hFFFFFFFF, 0, 1, 32'h104, 4'h2, 32'hA5A5A5A5, 0, 2'b00);
        vecs[11] = mk(1, 3'b010, 32'h010, 32'hCAFEF00D, 0, 0, 1, 32'h010, 4'hF, 32'hCAFEF00D, 0, 2'b00);
        vecs[12] = mk(1, 3'b001, 32'h201, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        vecs[13] = mk(1, 3'b100, 32'h100, 32'h22, 0, 0, 0, 0, 0, 0, 0, 2'b11);
        vecs[14] = mk(0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
        vecs[15] = mk(0, 3'b110, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
        vecs[16] = mk(0, 3'b001, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        vecs[17] = mk(1, 3'b000, 32'h103, 32'h0000007E, 0, 0, 1, 32'h100, 4'h8, 32'h7E7E7E7E, 0, 2'b00);
        vecs[18] = mk(0, 3'b000, 32'h101, 0, 32'h00007F00, 0, 1, 32'h100, 4'hF, 0, 32'h0000007F, 2'b00);
        vecs[19] = mk(0, 3'b001, 32'h100, 0, 32'h00008000, 3, 1, 32'h100, 4'hF, 0, 32'hFFFF8000, 2'b00);

        reset = 1'b0;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        req_valid_w = 0; req_we_w = 0; req_funct3_w = 0; req_addr_w = 0; req_wdata_w = 0;
        bus_ack_w = 0; bus_rdata_w = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset bus_req", 64'(bus_req), 64'd0);
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("reset err_code", 64'(err_code), 64'd0);
        checkOutput("reset bus_be", 64'(bus_be), 64'd0);
        checkOutput("reset stall_o", 64'(stall_o), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) applyStimulus(vecs[i], i);

        // Reset mid-access, then a stray ack: no response may appear
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        @(posedge clk); #1;
        checkOutput("rst_seq bus_req_acc1", 64'(bus_req), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_seq bus_req_after", 64'(bus_req), 64'd0);
        checkOutput("rst_seq rsp_valid_after", 64'(rsp_valid), 64'd0);
        reset = 1'b1; req_valid = 1'b0; bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checkOutput("rst_seq bus_req_late_ack", 64'(bus_req), 64'd0);
        checkOutput("rst_seq stall_idle", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        checkOutput("rst_seq rsp_valid_late_ack", 64'(rsp_valid), 64'd0);

        run64("w64 lwu", 0, 3'b110, 32'h4, 0, 64'h80000001_FFFFFFFF,
              32'h0, 8'hFF, 0, 64'h00000000_80000001);
        run64("w64 lw", 0, 3'b010, 32'h4, 0, 64'h80000001_FFFFFFFF,
              32'h0, 8'hFF, 0, 64'hFFFFFFFF_80000001);
        run64("w64 ld", 0, 3'b011, 32'h8, 0, 64'h01234567_89ABCDEF,
              32'h8, 8'hFF, 0, 64'h01234567_89ABCDEF);
        run64("w64 sb", 1, 3'b000, 32'h7, 64'h5A, 0,
              32'h0, 8'h80, 64'h5A5A5A5A_5A5A5A5A, 0);
        run64("w64 sw", 1, 3'b010, 32'h14, 64'h11223344, 0,
              32'h10, 8'hF0, 64'h11223344_11223344, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
